// File: rtl/v810_bus_ctlr_if.sv
// v810_bus_ctlr_if
// CPU-side V810 external bus seen by the bus controller.
//   a, ben, mrqn, rw, bcystn, dan, d_o : driven by the CPU (master)
//   d_i, readyn, szrqn                 : driven by the controller (slave)
// rw=1 is a read. All strobes are active-low except rw.
interface v810_bus_ctlr_if;
    logic [31:0] a;
    logic [3:0]  ben;
    logic        mrqn;
    logic        rw;
    logic        bcystn;
    logic        dan;
    logic [31:0] d_o;
    logic [31:0] d_i;
    logic        readyn;
    logic        szrqn;

    modport master (
        output a, ben, mrqn, rw, bcystn, dan, d_o,
        input  d_i, readyn, szrqn
    );

    modport slave (
        input  a, ben, mrqn, rw, bcystn, dan, d_o,
        output d_i, readyn, szrqn
    );
endinterface

// File: rtl/v810_bus_ctlr.sv
// v810_bus_ctlr
// Multi-region external bus controller for the V810. Each bus cycle is decoded
// against NREG programmable regions (base/mask on A[31:20]); the lowest matching
// region wins, gets its chip enable, and has its wait states inserted before
// READYn is returned. 16-bit regions request sizing (SZRQn) and have their low
// half-word mirrored onto both halves of the read data.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   ce_i             clock enable; nothing advances while low
//   bus              CPU bus (slave modport of v810_bus_ctlr_if)
//   reg_base_i       per-region A[31:20] match value
//   reg_mask_i       per-region compare mask (1 = compare bit)
//   reg_ws_i         per-region wait states
//   reg_dw16_i       per-region 16-bit flag
//   mem_nce_o        per-channel chip enable, active-low
//   mem_nwe_o/noe_o  shared write/output enables, active-low
//   mem_nbe_o        latched byte enables
//   mem_a_o          latched address
//   mem_di_o         write data to the channels (CPU D_O passed through)
//   mem_do_i         per-channel read data
//   berr_o           sticky bus error
//   berr_addr_o      address of the first erroring cycle
//   berr_clr_i       clears berr_o
//
// Build option: BUS_CTLR_TIMEOUT_EN
//   defined   - an unmatched cycle waits TIMEOUT (>= 1) CE cycles, then is
//               terminated with zero data and raises berr_o
//   undefined - an unmatched cycle is ignored; berr_o/berr_addr_o are tied 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no cycle in progress
// WAIT    | matched cycle, counting down wait states
// READY   | READYn asserted for one CE cycle; may accept the next start
// TOUT    | unmatched cycle, counting down to forced termination
module v810_bus_ctlr #(
    parameter int NREG    = 4,
    parameter int WSW     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce_i,
    v810_bus_ctlr_if.slave       bus,
    input  logic [NREG*12-1:0]   reg_base_i,
    input  logic [NREG*12-1:0]   reg_mask_i,
    input  logic [NREG*WSW-1:0]  reg_ws_i,
    input  logic [NREG-1:0]      reg_dw16_i,
    output logic [NREG-1:0]      mem_nce_o,
    output logic                 mem_nwe_o,
    output logic                 mem_noe_o,
    output logic [3:0]           mem_nbe_o,
    output logic [31:0]          mem_a_o,
    output logic [31:0]          mem_di_o,
    input  logic [NREG*32-1:0]   mem_do_i,
    output logic                 berr_o,
    output logic [31:0]          berr_addr_o,
    input  logic                 berr_clr_i
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_TOUT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [WSW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            hit_q, hit_d;
    logic            rw_q, rw_d;
    logic            dw16_q, dw16_d;
    logic [31:0]     a_q, a_d;
    logic [3:0]      ben_q, ben_d;

    logic            start;
    logic            dec_hit;
    logic [IW-1:0]   dec_idx;
    logic [WSW-1:0]  dec_ws;
    logic            dec_dw16;
    logic            active;
    logic [31:0]     rd_sel;
    logic            unused_ok;

`ifdef BUS_CTLR_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            berr_q, berr_d;
    logic [31:0]     berr_addr_q, berr_addr_d;
    logic            err_evt;
`endif

    // Region decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_ws   = '0;
        dec_dw16 = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (((bus.a[31:20] ^ reg_base_i[i*12 +: 12]) & reg_mask_i[i*12 +: 12]) == 12'h000) begin
                dec_hit  = 1'b1;
                dec_idx  = IW'(i);
                dec_ws   = reg_ws_i[i*WSW +: WSW];
                dec_dw16 = reg_dw16_i[i];
            end
        end
    end

    assign start = ~bus.bcystn & ~bus.mrqn & ((state_q == ST_IDLE) | (state_q == ST_READY));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        rw_d    = rw_q;
        dw16_d  = dw16_q;
        a_d     = a_q;
        ben_d   = ben_q;
`ifdef BUS_CTLR_TIMEOUT_EN
        tcnt_d      = tcnt_q;
        berr_d      = berr_q;
        berr_addr_d = berr_addr_q;
        err_evt     = 1'b0;
`endif

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == WSW'(1)) state_d = ST_READY;
                else                  cnt_d   = cnt_q - 1'b1;
            end
            ST_READY: state_d = ST_IDLE;
            ST_TOUT: begin
`ifdef BUS_CTLR_TIMEOUT_EN
                if (tcnt_q == TW'(1)) state_d = ST_READY;
                else                  tcnt_d  = tcnt_q - 1'b1;
`else
                state_d = ST_IDLE;
`endif
            end
            default: ;
        endcase

        // A start in READY overrides the return to IDLE (back-to-back cycle).
        if (start) begin
            a_d    = bus.a;
            ben_d  = bus.ben;
            rw_d   = bus.rw;
            hit_d  = dec_hit;
            idx_d  = dec_idx;
            dw16_d = dec_dw16;
            if (dec_hit) begin
                if (dec_ws == '0) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = dec_ws;
                end
            end else begin
`ifdef BUS_CTLR_TIMEOUT_EN
                state_d = ST_TOUT;
                tcnt_d  = TW'(TIMEOUT);
                err_evt = 1'b1;
`else
                state_d = ST_IDLE;
`endif
            end
        end

`ifdef BUS_CTLR_TIMEOUT_EN
        // A new error beats a simultaneous clear and re-captures the address.
        if (err_evt) begin
            berr_d = 1'b1;
            if (!berr_q || berr_clr_i) berr_addr_d = bus.a;
        end else if (berr_clr_i) begin
            berr_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            rw_q    <= 1'b1;
            dw16_q  <= 1'b0;
            a_q     <= '0;
            ben_q   <= 4'hF;
        end else if (ce_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            rw_q    <= rw_d;
            dw16_q  <= dw16_d;
            a_q     <= a_d;
            ben_q   <= ben_d;
        end
    end

`ifdef BUS_CTLR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q      <= '0;
            berr_q      <= 1'b0;
            berr_addr_q <= '0;
        end else if (ce_i) begin
            tcnt_q      <= tcnt_d;
            berr_q      <= berr_d;
            berr_addr_q <= berr_addr_d;
        end
    end

    assign berr_o      = berr_q;
    assign berr_addr_o = berr_addr_q;
    assign unused_ok   = bus.dan;
`else
    assign berr_o      = 1'b0;
    assign berr_addr_o = '0;
    assign unused_ok   = ^{bus.dan, berr_clr_i, TIMEOUT[0]};
`endif

    // Strobes follow registered state only, so CE=0 holds them steady.
    assign active = hit_q & ((state_q == ST_WAIT) | (state_q == ST_READY));

    always_comb begin
        mem_nce_o = '1;
        rd_sel    = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx_q == IW'(i)) begin
                rd_sel = mem_do_i[i*32 +: 32];
                if (active) mem_nce_o[i] = 1'b0;
            end
        end
    end

    assign mem_noe_o  = ~(active & rw_q);
    assign mem_nwe_o  = ~(active & ~rw_q);
    assign mem_nbe_o  = ben_q;
    assign mem_a_o    = a_q;
    assign mem_di_o   = bus.d_o;
    assign bus.szrqn  = ~(active & dw16_q);
    assign bus.readyn = ~(state_q == ST_READY);

    // Read data is zero outside READY so it can be wire-ORed with other sources.
    assign bus.d_i = (state_q == ST_READY && hit_q)
                   ? (dw16_q ? {rd_sel[15:0], rd_sel[15:0]} : rd_sel)
                   : 32'h0;

endmodule

// File: tb/tb_v810_bus_ctlr.sv
module tb_v810_bus_ctlr;
    localparam int NREG    = 4;
    localparam int WSW     = 4;
    localparam int TIMEOUT = 255;
    localparam logic [NREG-1:0] NCE_OFF = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic berr_clr = 1'b0;

    v810_bus_ctlr_if bus();

    logic [NREG*12-1:0]  reg_base = '0;
    logic [NREG*12-1:0]  reg_mask = '0;
    logic [NREG*WSW-1:0] reg_ws = '0;
    logic [NREG-1:0]     reg_dw16 = '0;
    logic [NREG*32-1:0]  mem_do = '0;
    logic [NREG-1:0]     mem_nce;
    logic                mem_nwe, mem_noe;
    logic [3:0]          mem_nbe;
    logic [31:0]         mem_a, mem_di;
    logic                berr;
    logic [31:0]         berr_addr;

    v810_bus_ctlr #(.NREG(NREG), .WSW(WSW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ce_i(ce), .bus(bus),
        .reg_base_i(reg_base), .reg_mask_i(reg_mask), .reg_ws_i(reg_ws), .reg_dw16_i(reg_dw16),
        .mem_nce_o(mem_nce), .mem_nwe_o(mem_nwe), .mem_noe_o(mem_noe), .mem_nbe_o(mem_nbe),
        .mem_a_o(mem_a), .mem_di_o(mem_di), .mem_do_i(mem_do),
        .berr_o(berr), .berr_addr_o(berr_addr), .berr_clr_i(berr_clr)
    );

    always #5 clk = ~clk;

    // Programmed region table and channel read data (the reference copy).
    logic [11:0]    cfg_base[NREG];
    logic [11:0]    cfg_mask[NREG];
    logic [WSW-1:0] cfg_ws[NREG];
    bit             cfg_dw[NREG];
    logic [31:0]    chan_do[NREG];

    // Expectations for the cycle in flight.
    bit          m_hit, m_rw, m_dw;
    int          m_idx, m_lat;
    logic [31:0] m_addr, m_wd, m_rd;
    logic [3:0]  m_ben;
    bit          m_berr = 0;
    logic [31:0] m_berr_addr = '0;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ad, output bit hit, output int idx);
        hit = 0;
        idx = 0;
        for (int i = 0; i < NREG; i++)
            if (!hit && (((ad[31:20] ^ cfg_base[i]) & cfg_mask[i]) == 12'h000)) begin
                hit = 1;
                idx = i;
            end
    endfunction

    task automatic set_region(input int i, input logic [11:0] b, input logic [11:0] m,
                              input logic [WSW-1:0] ws, input bit dw);
        cfg_base[i] = b;
        cfg_mask[i] = m;
        cfg_ws[i]   = ws;
        cfg_dw[i]   = dw;
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NREG; i++) begin
            reg_base[i*12 +: 12]   = cfg_base[i];
            reg_mask[i*12 +: 12]   = cfg_mask[i];
            reg_ws[i*WSW +: WSW]   = cfg_ws[i];
            reg_dw16[i]            = cfg_dw[i];
            mem_do[i*32 +: 32]     = chan_do[i];
        end
    endtask

    task automatic scramble_cfg();
        for (int i = 0; i < NREG; i++) begin
            reg_base[i*12 +: 12] = 12'($urandom);
            reg_mask[i*12 +: 12] = 12'($urandom);
            reg_ws[i*WSW +: WSW] = WSW'($urandom);
            reg_dw16[i]          = 1'($urandom);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " readyn"}, bus.readyn, 1'b1);
        chk({tag, " szrqn"}, bus.szrqn, 1'b1);
        chk({tag, " nce"}, mem_nce, NCE_OFF);
        chk({tag, " nwe"}, mem_nwe, 1'b1);
        chk({tag, " noe"}, mem_noe, 1'b1);
        chk({tag, " nbe"}, mem_nbe, 4'hF);
        chk({tag, " mem_a"}, mem_a, 32'h0);
        chk({tag, " d_i"}, bus.d_i, 32'h0);
        chk({tag, " berr"}, berr, 1'b0);
        chk({tag, " berr_addr"}, berr_addr, 32'h0);
    endtask

    task automatic chk_active(input int k);
        logic [NREG-1:0] e_nce;
        logic e_rdy, e_noe, e_nwe, e_sz;
        logic [31:0] e_di;
        e_nce = NCE_OFF;
        if (m_hit) e_nce[m_idx] = 1'b0;
        e_rdy = (k == m_lat) ? 1'b0 : 1'b1;
        e_noe = m_hit ? !m_rw : 1'b1;
        e_nwe = m_hit ? m_rw : 1'b1;
        e_sz  = (m_hit && m_dw) ? 1'b0 : 1'b1;
        e_di  = (k == m_lat) ? m_rd : 32'h0;
        chk("readyn", bus.readyn, e_rdy);
        chk("nce", mem_nce, e_nce);
        chk("noe", mem_noe, e_noe);
        chk("nwe", mem_nwe, e_nwe);
        chk("szrqn", bus.szrqn, e_sz);
        chk("d_i", bus.d_i, e_di);
        chk("mem_a", mem_a, m_addr);
        chk("mem_nbe", mem_nbe, m_ben);
        chk("mem_di", mem_di, m_wd);
        chk("berr", berr, m_berr);
        chk("berr_addr", berr_addr, m_berr_addr);
    endtask

    // Drives a start at the current negedge; returns at the negedge after the start edge.
    task automatic start_txn(input logic [31:0] ad, input bit rw, input logic [3:0] ben,
                             input logic [31:0] wd, input bit clr);
        bit h;
        int ix;
        apply_cfg();
        bus.a = ad; bus.rw = rw; bus.ben = ben; bus.d_o = wd;
        bus.bcystn = 1'b0; bus.mrqn = 1'b0; ce = 1'b1;
        berr_clr = clr;
        ref_decode(ad, h, ix);
        m_hit = h; m_idx = ix; m_addr = ad; m_rw = rw; m_ben = ben; m_wd = wd;
        m_dw  = h ? cfg_dw[ix] : 1'b0;
        m_lat = h ? int'(cfg_ws[ix]) : TIMEOUT;
        if (!h)         m_rd = 32'h0;
        else if (m_dw)  m_rd = {chan_do[ix][15:0], chan_do[ix][15:0]};
        else            m_rd = chan_do[ix];
`ifdef BUS_CTLR_TIMEOUT_EN
        if (!h) begin
            if (!m_berr || clr) m_berr_addr = ad;
            m_berr = 1;
        end else if (clr) begin
            m_berr = 0;
        end
`endif
        @(negedge clk);
        bus.bcystn = 1'b1;
        berr_clr = 1'b0;
    endtask

    // Follows the cycle; with chain set it returns in READY so the caller can start the next one.
    task automatic follow(input bit chain, input bit stall, input bit scramble);
        int k = 0;
        int n = 0;
`ifndef BUS_CTLR_TIMEOUT_EN
        if (!m_hit) begin
            ce = 1'b1;
            repeat (3) begin
                chk("miss readyn", bus.readyn, 1'b1);
                chk("miss nce", mem_nce, NCE_OFF);
                chk("miss szrqn", bus.szrqn, 1'b1);
                chk("miss mem_a", mem_a, m_addr);
                chk("miss berr", berr, 1'b0);
                @(negedge clk);
            end
            bus.mrqn = 1'b1;
            return;
        end
`endif
        forever begin
            chk_active(k);
            if (n == 0 && scramble) scramble_cfg();
            if (k == m_lat && chain) return;
            ce = (stall && n < 60 && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            n++;
            if (n > 600) begin
                chk("cycle budget", 32'(n), 32'(m_lat));
                break;
            end
            if (ce) begin
                if (k == m_lat) break;
                k++;
            end
        end
        chk("idle readyn", bus.readyn, 1'b1);
        chk("idle nce", mem_nce, NCE_OFF);
        bus.mrqn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ad, lo;
        logic [11:0] hi;
        int r;
        bit chain;

        bus.a = '0; bus.ben = 4'hF; bus.mrqn = 1'b1; bus.rw = 1'b1;
        bus.bcystn = 1'b1; bus.dan = 1'b1; bus.d_o = '0;
        for (int i = 0; i < NREG; i++) begin
            set_region(i, 12'h001 + 12'(i), 12'hFFF, '0, 1'b0);
            chan_do[i] = '0;
        end

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        ce = 1'b1;
        @(negedge clk);

        // 16-bit zero-wait read with mirrored data
        set_region(0, 12'hFFF, 12'hFFF, 4'd0, 1'b1);
        set_region(1, 12'h000, 12'h800, 4'd3, 1'b0);
        set_region(2, 12'h123, 12'hF00, 4'd2, 1'b0);
        set_region(3, 12'hFF0, 12'hFFF, 4'd1, 1'b1);
        chan_do[0] = 32'h0000BEEF;
        chan_do[1] = 32'hCAFE0001;
        start_txn(32'hFFFFFFF0, 1'b1, 4'h0, 32'h0, 1'b0);
        chk("tp1 d_i", bus.d_i, 32'hBEEFBEEF);
        chk("tp1 nce", mem_nce, 4'b1110);
        follow(1'b0, 1'b0, 1'b0);

        // 32-bit write with three wait states; REG_* disturbed mid-cycle
        start_txn(32'h00000100, 1'b0, 4'h0, 32'h12345678, 1'b0);
        chk("tp2 nwe", mem_nwe, 1'b0);
        follow(1'b0, 1'b0, 1'b1);

        // back-to-back zero-wait reads
        start_txn(32'hFFFFFFF0, 1'b1, 4'h3, 32'h0, 1'b0);
        follow(1'b1, 1'b0, 1'b0);
        chan_do[0] = 32'h5555AAAA;
        start_txn(32'hFFF00004, 1'b1, 4'hC, 32'h0, 1'b0);
        chk("b2b readyn", bus.readyn, 1'b0);
        follow(1'b0, 1'b0, 1'b0);

        // overlapping regions 0 and 2, with CE stalls during WAIT
        set_region(0, 12'h120, 12'hFF0, 4'd5, 1'b0);
        set_region(2, 12'h123, 12'hF00, 4'd2, 1'b1);
        chan_do[0] = 32'h0BADF00D;
        chan_do[2] = 32'h22222222;
        start_txn(32'h12300004, 1'b1, 4'h0, 32'h0, 1'b0);
        chk("overlap nce", mem_nce, 4'b1110);
        follow(1'b0, 1'b1, 1'b0);

        // reset during WAIT (count 4 of 7), then a normal cycle
        set_region(1, 12'h000, 12'hFFF, 4'd3, 1'b0);
        set_region(3, 12'h0AB, 12'hFFF, 4'd7, 1'b0);
        chan_do[3] = 32'h33334444;
        start_txn(32'h0AB00010, 1'b1, 4'h1, 32'h0, 1'b0);
        ce = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre-rst nce", mem_nce, 4'b0111);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async rst");
        @(negedge clk);
        chk_reset_vals("held rst");
        rst_n = 1'b1;
        bus.mrqn = 1'b1;
        m_berr = 0;
        m_berr_addr = '0;
        @(negedge clk);
        start_txn(32'h0AB00020, 1'b1, 4'h0, 32'h0, 1'b0);
        follow(1'b0, 1'b0, 1'b0);

        // unmatched access
        for (int i = 0; i < NREG; i++) set_region(i, 12'h001 + 12'(i), 12'hFFF, 4'd1, 1'b0);
        start_txn(32'h40000000, 1'b1, 4'h0, 32'h0, 1'b0);
        follow(1'b0, 1'b0, 1'b0);
`ifdef BUS_CTLR_TIMEOUT_EN
        chk("tout berr", berr, 1'b1);
        chk("tout berr_addr", berr_addr, 32'h40000000);
        ce = 1'b1;
        berr_clr = 1'b1;
        @(negedge clk);
        berr_clr = 1'b0;
        m_berr = 0;
        chk("berr clr", berr, 1'b0);
`else
        chk("no-tout berr_addr", berr_addr, 32'h0);
`endif

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (t % 8 == 0)
                for (int i = 0; i < NREG; i++)
                    set_region(i, 12'($urandom), 12'($urandom) | 12'h800,
                               WSW'($urandom_range(0, 6)), 1'($urandom));
            for (int i = 0; i < NREG; i++) chan_do[i] = $urandom;
            r = $urandom_range(0, NREG - 1);
            lo = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                ad = $urandom;
            end else begin
                hi = (cfg_base[r] & cfg_mask[r]) | (12'($urandom) & ~cfg_mask[r]);
                ad = {hi, lo[19:0]};
            end
            chain = (t != 39) && ($urandom_range(0, 2) == 0);
            start_txn(ad, 1'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 5) == 0));
            follow(chain, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
